// File: rtl/pipelined_shifter.sv
// Log-stage pipelined shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides.
// Stage k applies the 2^k term of the shift amount; one result per cycle.
module pipelined_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    input  logic               shift_enable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   shifted_output
);

    localparam int L = SHAMT_W;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_e;

    // Boundary b is the operation entering stage b; boundary L feeds the outputs.
    logic               b_valid  [L+1];
    logic [WIDTH-1:0]   b_data   [L+1];
    logic               b_enable [L+1];
    shift_mode_e        b_mode   [L];
    logic               b_sign   [L];
    logic [SHAMT_W-1:0] b_shamt  [L];
    logic [L-1:0]       adv;

    assign b_valid[0]  = in_valid;
    assign b_data[0]   = data_operandA;
    assign b_enable[0] = shift_enable;
    assign b_mode[0]   = shift_mode_e'(ctrl_mode);
    assign b_sign[0]   = data_operandA[WIDTH-1];
    assign b_shamt[0]  = ctrl_shiftamt;

    // A stage may load when it, or every stage after it up to a consuming
    // output, has room; bubbles anywhere downstream open the path.
    always_comb begin
        logic chain;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        adv   = '0;
        chain = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            chain  = chain || !b_valid[k+1];
            adv[k] = chain;
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int DIST = 1 << k;

        logic [WIDTH-1:0] shifted;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic             enable_q;

        always_comb begin
            shifted = b_data[k];
            if (b_shamt[k][k]) begin
                case (b_mode[k])
                    MODE_SLL: shifted = b_data[k] << DIST;
                    MODE_SRL: shifted = b_data[k] >> DIST;
                    MODE_SRA: shifted = {{DIST{b_sign[k]}}, b_data[k][WIDTH-1:DIST]};
                    MODE_ROL: shifted = {b_data[k][WIDTH-DIST-1:0],
                                         b_data[k][WIDTH-1:WIDTH-DIST]};
                    default:  shifted = b_data[k];
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments only.
        // NOTE: data is reset as well so an idle output reads as zero.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid_q  <= 1'b0;
                data_q   <= '0;
                enable_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (adv[k]) begin
                valid_q <= b_valid[k];
                if (b_valid[k]) begin
                    data_q   <= shifted;
                    enable_q <= b_enable[k];
                end
            end
        end

        assign b_valid[k+1]  = valid_q;
        assign b_data[k+1]   = data_q;
        assign b_enable[k+1] = enable_q;

        // Only stages with a successor carry mode, sign and the unconsumed shamt bits.
        if (k < L - 1) begin : g_ctrl
            shift_mode_e          mode_q;
            logic                 sign_q;
            logic [SHAMT_W-1:k+1] shamt_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    mode_q  <= MODE_SLL;
                    sign_q  <= 1'b0;
                    shamt_q <= '0;
                end else if (!flush && adv[k] && b_valid[k]) begin
                    mode_q  <= b_mode[k];
                    sign_q  <= b_sign[k];
                    shamt_q <= b_shamt[k][SHAMT_W-1:k+1];
                end
            end

            assign b_mode[k+1]  = mode_q;
            assign b_sign[k+1]  = sign_q;
            assign b_shamt[k+1] = {shamt_q, {(k + 1){1'b0}}};
        end
    end

    assign in_ready       = adv[0];
    assign out_valid      = b_valid[L];
    assign shifted_output = b_data[L] & {WIDTH{b_enable[L]}};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: expected results are queued on
// accept and compared in order on every output handshake.
module tb_pipelined_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA = '0;
    logic [SHAMT_W-1:0] ctrl_shiftamt = '0;
    logic [1:0]         ctrl_mode = '0;
    logic               shift_enable = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   shifted_output;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [WIDTH-1:0] sb [$];

    pipelined_shifter #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .ctrl_mode      (ctrl_mode),
        .shift_enable   (shift_enable),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .shifted_output (shifted_output)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] a,
                                               input logic [1:0] m, input logic en);
        logic [2*WIDTH-1:0] dd;
        logic [WIDTH-1:0]   r;
        dd = '0;
        case (m)
            2'd0:    r = d << a;
            2'd1:    r = d >> a;
            2'd2:    r = $signed(d) >>> a;
            default: begin
                dd = {d, d} << a;
                r  = dd[2*WIDTH-1:WIDTH];
            end
        endcase
        return en ? r : '0;
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] a,
                         input logic [1:0] m, input logic en);
        in_valid      = v;
        data_operandA = d;
        ctrl_shiftamt = a;
        ctrl_mode     = m;
        shift_enable  = en;
    endtask

    // One clock: observe handshakes mid-cycle, then step past the rising edge.
    task automatic tick(output bit acc);
        logic [WIDTH-1:0] exp;
        acc = 1'b0;
        @(negedge clock);
        if (reset && !flush) begin
            if (out_valid && out_ready) begin
                tests++;
                pops++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: got %h, required no output", shifted_output);
                end else begin
                    exp = sb.pop_front();
                    if (shifted_output !== exp) begin
                        fails++;
                        $display("FAIL sb_result: got %h, required %h", shifted_output, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(data_operandA, ctrl_shiftamt, ctrl_mode, shift_enable));
                acc = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input int budget, output bit seen);
        bit d;
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick(d);
            n++;
        end
        seen = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 2'd0, 0);
        #2;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        tests++;
        if (shifted_output !== '0) begin fails++; $display("FAIL reset_output: got %h, required 0", shifted_output); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_latency();
        bit acc;
        int lat = 0;
        out_ready = 1'b1;
        drive(1, 32'h0000_0001, 5'd31, 2'd0, 1);
        tick(acc);
        drive(0, '0, '0, 2'd0, 0);
        tests++;
        if (!acc) begin fails++; $display("FAIL latency_accept: got 0, required 1"); end
        while (out_valid !== 1'b1 && lat < 10) begin
            tick(acc);
            lat++;
        end
        tests++;
        if (lat != 4) begin fails++; $display("FAIL latency_edges: got %0d, required 4", lat); end
        tests++;
        if (shifted_output !== 32'h8000_0000) begin
            fails++;
            $display("FAIL latency_value: got %h, required 80000000", shifted_output);
        end
        tick(acc);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_drain: got %b, required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_b2b [3] = '{32'h0800_0000, 32'hF800_0000, 32'h0000_0003};
        bit acc;
        bit seen;
        out_ready = 1'b1;
        drive(1, 32'h8000_0000, 5'd4, 2'd1, 1); tick(acc);
        drive(1, 32'h8000_0000, 5'd4, 2'd2, 1); tick(acc);
        drive(1, 32'h8000_0001, 5'd1, 2'd3, 1); tick(acc);
        drive(0, '0, '0, 2'd0, 0);
        wait_out(10, seen);
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (out_valid !== 1'b1 || shifted_output !== exp_b2b[j]) begin
                fails++;
                $display("FAIL b2b_%0d: got valid=%b data=%h, required valid=1 data=%h",
                         j, out_valid, shifted_output, exp_b2b[j]);
            end
            tick(acc);
        end
    endtask

    task automatic test_enable();
        bit acc;
        bit seen;
        out_ready = 1'b1;
        drive(1, 32'hFFFF_FFFF, 5'd3, 2'd0, 0);
        tick(acc);
        drive(0, '0, '0, 2'd0, 0);
        wait_out(10, seen);
        tests++;
        if (!seen || shifted_output !== '0) begin
            fails++;
            $display("FAIL enable_zero: got valid=%b data=%h, required valid=1 data=00000000", seen, shifted_output);
        end
        tick(acc);
    endtask

    task automatic test_zero_shift();
        bit acc;
        bit seen;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            drive(1, 32'hA5C3_5A3C ^ WIDTH'(m), '0, 2'(m), 1);
            tick(acc);
        end
        drive(0, '0, '0, 2'd0, 0);
        for (int m = 0; m < 4; m++) begin
            wait_out(10, seen);
            tests++;
            if (!seen || shifted_output !== (32'hA5C3_5A3C ^ WIDTH'(m))) begin
                fails++;
                $display("FAIL zero_shift_mode%0d: got %h, required %h", m, shifted_output, 32'hA5C3_5A3C ^ WIDTH'(m));
            end
            tick(acc);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int idx = 0;
        int p0;
        int cyc = 0;
        logic [WIDTH-1:0] held;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1, WIDTH'(idx), SHAMT_W'(idx), 2'd0, 1);
            tick(acc);
            if (acc) idx++;
        end
        tests++;
        if (idx != 5) begin fails++; $display("FAIL bp_accepts: got %0d, required 5", idx); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        held = shifted_output;
        tests++;
        if (out_valid !== 1'b1 || held !== '0) begin
            fails++;
            $display("FAIL bp_head: got valid=%b data=%h, required valid=1 data=00000000", out_valid, held);
        end
        for (int c = 0; c < 3; c++) tick(acc);
        tests++;
        if (out_valid !== 1'b1 || shifted_output !== held) begin
            fails++;
            $display("FAIL bp_hold: got valid=%b data=%h, required valid=1 data=%h", out_valid, shifted_output, held);
        end
        p0 = pops;
        out_ready = 1'b1;
        while ((pops - p0) < 8 && cyc < 100) begin
            if (idx < 8) drive(1, WIDTH'(idx), SHAMT_W'(idx), 2'd0, 1);
            else drive(0, '0, '0, 2'd0, 0);
            tick(acc);
            if (acc) idx++;
            out_ready = ~out_ready;
            cyc++;
        end
        drive(0, '0, '0, 2'd0, 0);
        out_ready = 1'b1;
        tests++;
        if ((pops - p0) != 8 || idx != 8 || sb.size() != 0) begin
            fails++;
            $display("FAIL bp_drain: got pops=%0d accepts=%0d pending=%0d, required 8/8/0", pops - p0, idx, sb.size());
        end
    endtask

    task automatic test_random();
        bit acc;
        int n_acc = 0;
        int cyc = 0;
        while ((n_acc < 60 || sb.size() != 0) && cyc < 2000) begin
            if (n_acc < 60)
                drive(1'($urandom_range(0, 1)), $urandom, SHAMT_W'($urandom_range(0, 31)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0));
            else
                drive(0, '0, '0, 2'd0, 0);
            out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) n_acc++;
            cyc++;
        end
        drive(0, '0, '0, 2'd0, 0);
        out_ready = 1'b1;
        tests++;
        if (n_acc != 60 || sb.size() != 0) begin
            fails++;
            $display("FAIL random_drain: got accepts=%0d pending=%0d, required 60/0", n_acc, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int n_acc = 0;
        int seen_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1111_0000 + WIDTH'(i), SHAMT_W'(i + 1), 2'd3, 1);
            tick(acc);
            if (acc) n_acc++;
        end
        drive(0, '0, '0, 2'd0, 0);
        tests++;
        if (n_acc != 3) begin fails++; $display("FAIL rst_mid_accepts: got %0d, required 3", n_acc); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || shifted_output !== '0) begin
            fails++;
            $display("FAIL rst_mid_async: got valid=%b ready=%b data=%h, required 0/1/00000000",
                     out_valid, in_ready, shifted_output);
        end
        reset = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(acc);
            if (out_valid === 1'b1) seen_out++;
        end
        tests++;
        if (seen_out != 0) begin fails++; $display("FAIL rst_mid_ghost: got %0d outputs, required 0", seen_out); end
    endtask

    task automatic test_flush();
        bit acc;
        bit seen;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h0000_0100 << i, 5'd1, 2'd0, 1);
            tick(acc);
        end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_full: got in_ready=%b, required 0", in_ready); end
        drive(1, 32'hDEAD_BEEF, 5'd0, 2'd0, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        drive(0, '0, '0, 2'd0, 0);
        sb.delete();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_clear: got valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
        drive(1, 32'h0000_0100, 5'd8, 2'd1, 1);
        tick(acc);
        drive(0, '0, '0, 2'd0, 0);
        wait_out(10, seen);
        tests++;
        if (!seen || shifted_output !== 32'h0000_0001) begin
            fails++;
            $display("FAIL flush_after: got valid=%b data=%h, required valid=1 data=00000001", seen, shifted_output);
        end
        tick(acc);
        for (int c = 0; c < 6; c++) tick(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_enable();
        test_zero_shift();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_flush();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined 32-bit-default shifter for the processor ALU path. It generalises the single-cycle logical-left shifter to any power-of-two width and four modes: SLL, SRL, SRA and ROL. Decomposition is log-stage: one register per shift-amount bit. A valid/ready handshake on both sides gives one result per cycle with backpressure. It sits between operand decode and ALU result select, and is used for multi-cycle shift instructions.

## Interface

Parameters:
- WIDTH, 32, data width; power of two, ≥ 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width and pipeline depth L; derived, never overridden.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all pipeline state immediately.
- flush, input, 1, synchronous; clears all stage valids at the next edge.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, block accepts the operation this cycle.
- data_operandA, input, WIDTH, operand.
- ctrl_shiftamt, input, SHAMT_W, shift amount, 0..WIDTH-1.
- ctrl_mode, input, 2, shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- shift_enable, input, 1, 0 forces the result to zero; carried with the operation.
- out_valid, output, 1, result held on shifted_output.
- out_ready, input, 1, consumer takes the result this cycle.
- shifted_output, output, WIDTH, result.

## Operation

- Pipeline has L = SHAMT_W stages. Stage k holds: valid, data (WIDTH), mode, enable, and the unconsumed shamt bits [SHAMT_W-1:k+1].
- Stage k shifts its input by 2^k when shamt bit k is 1; otherwise it passes the data unchanged.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill from the MSB with the original data_operandA[WIDTH-1]. The sign is captured at stage 0 and carried.
  - ROL: rotate left; no fill.
- Stage L-1 registers drive out_valid and shifted_output. shifted_output = stage data AND enable, so it is all-zero when shift_enable was 0.
- Advance rule:
  - adv(L-1) = !valid(L-1) || out_ready.
  - adv(k) = !valid(k) || adv(k+1).
  - in_ready = adv(0), a combinational function of the stage valids and out_ready.
- Stage k loads from stage k-1 (or from the inputs, for k=0) when adv(k) is 1. The loaded valid equals the upstream valid, so bubbles propagate and collapse.
- Stage k holds its contents when adv(k) is 0.
- Results leave in acceptance order. No loss, no duplication.
- ctrl_shiftamt = 0 returns data_operandA unchanged in every mode (gated by enable).
- flush: all valids go to 0 at the next edge. The input offered in the same cycle is not accepted and out_ready is ignored; flush wins over all transfers.
- Data registers are not required to clear on flush, only the valids.

## Timing

- Reset values: all stage valids 0; all stage data 0. Hence out_valid = 0 and shifted_output = 0.
- in_ready = 1 during and after reset (all valids are 0).
- Reset asserted mid-operation: all in-flight operations are discarded and none is ever emitted. After release, the first accept is possible at the first edge.
- Latency: an operation accepted at edge N (in_valid && in_ready) shows out_valid = 1 right after edge N+L-1. That is 5 edges including N for WIDTH = 32, and 1 edge for WIDTH = 2.
- Throughput: 1 op/cycle while out_ready stays 1.
- Full condition: all L stages valid and out_ready = 0 → in_ready = 0.
- Simultaneous pop and push when full: with out_ready = 1, in_ready = 1 in the same cycle, and both transfers occur at the same edge.
- While out_valid = 1 and out_ready = 0, shifted_output and out_valid are held stable.
- No combinational path from in_valid or data inputs to any output. The only combinational path is out_ready → in_ready.

## Test plan

- Reset, then apply SLL 0x00000001 by 31 with enable = 1 and out_ready = 1 → shifted_output = 0x80000000 and out_valid = 1 after edge N+4.
- Three back-to-back ops 0x80000000 by 4:
  - SRL → 0x08000000.
  - SRA → 0xF8000000.
  - ROL 0x80000001 by 1 → 0x00000003.
  - Required response: results on three consecutive cycles, in order.
- shift_enable = 0 on SLL 0xFFFFFFFF by 3 → result 0x00000000 with out_valid = 1.
- Backpressure:
  - Stimulus: out_ready = 0 while streaming 8 distinct ops (operand i, SLL by i).
  - Required: in_ready drops after 5 accepts, and shifted_output holds 0x00000000+op0's result stable.
  - Then toggle out_ready 1,0,1,…: all 8 results (i<<i) arrive in order, with none dropped or duplicated.
- Accept 3 ops, then pulse reset low asynchronously between edges → out_valid = 0 immediately. None of the 3 ever appear, and in_ready = 1.
- flush with a full pipeline and in_valid = 1 → next cycle all valids are 0 and the offered op is not accepted. A subsequent op, SRL 0x00000100 by 8, yields 0x00000001.
